// File: rtl/pipeline_hazard_sequencer.sv
// Pipeline hazard sequencer for the 5-stage RISC-V core.
// It drives the per-stage enables and flushes for these cases: load-use
// stalls, taken branches and jumps, data-memory wait states, and the halt
// drain. It also keeps a saturating count of the cycles in which the PC was
// held.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | normal issue; resolves halt, branch and load-use hazards
// MEMWAIT | data memory busy; whole pipeline frozen, timeout counting
// DRAIN   | halt left EX; fetch stopped, MEM/WB retire the older ops
// HALTED  | core stopped; sticky until reset

module pipeline_hazard_sequencer #(
    parameter int DRAIN_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_halt,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_en,
    output logic             halted,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int BUSY_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [BUSY_W-1:0]  BUSY_LIMIT = BUSY_W'(MEM_TIMEOUT);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT =
        (DRAIN_CYCLES > 1) ? DRAIN_W'(DRAIN_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MEMWAIT = 2'd1,
        S_DRAIN   = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [BUSY_W-1:0]  busy_cnt, busy_nxt, busy_inc;
    logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
    logic               err_set;
    logic               load_use;

    assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                      ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

    // busy_cnt is zero whenever the pipeline is not frozen, so a single
    // increment path also covers the first busy cycle out of RUN.
    assign busy_inc = busy_cnt + BUSY_W'(1);

    assign halted = (state == S_HALTED);

    // State register, wait/drain counters and sticky memory error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_RUN;
            busy_cnt  <= '0;
            drain_cnt <= '0;
            mem_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy_cnt  <= busy_nxt;
            drain_cnt <= drain_nxt;
            if (err_set) begin
                mem_error <= 1'b1;
            end
        end
    end

    // Next-state and stage-control decode, mem_busy > halt > branch > load-use
    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_en     = 1'b0;
        state_nxt   = state;
        busy_nxt    = busy_cnt;
        drain_nxt   = drain_cnt;
        err_set     = 1'b0;

        case (state)
            S_RUN, S_MEMWAIT: begin
                if (mem_busy) begin
                    busy_nxt = busy_inc;
                    if (busy_inc >= BUSY_LIMIT) begin
                        state_nxt = S_HALTED;
                        err_set   = 1'b1;
                    end else begin
                        state_nxt = S_MEMWAIT;
                    end
                end else begin
                    busy_nxt  = '0;
                    state_nxt = S_RUN;
                    if (ex_halt) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        pipe_en     = 1'b1;
                        drain_nxt   = DRAIN_INIT;
                        state_nxt   = S_DRAIN;
                    end else if (ex_branch_taken) begin
                        pc_en       = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        pipe_en     = 1'b1;
                    end else if (load_use) begin
                        id_ex_flush = 1'b1;
                        pipe_en     = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                        pipe_en  = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                id_ex_flush = 1'b1;
                if (mem_busy) begin
                    busy_nxt = busy_inc;
                    if (busy_inc >= BUSY_LIMIT) begin
                        state_nxt = S_HALTED;
                        err_set   = 1'b1;
                    end
                end else begin
                    busy_nxt = '0;
                    pipe_en  = 1'b1;
                    // The halt cycle in RUN counts as the first drain cycle.
                    // drain_cnt therefore reaches zero on this edge, and the
                    // core halts right after it.
                    if (drain_cnt <= DRAIN_W'(1)) begin
                        drain_nxt = '0;
                        state_nxt = S_HALTED;
                    end else begin
                        drain_nxt = drain_cnt - DRAIN_W'(1);
                    end
                end
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase

        // While reset is held, freeze every stage and keep the flushes asserted
        if (reset) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            pipe_en     = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    // Saturating count of the cycles in which the PC was held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (!pc_en && (state != S_HALTED) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
